// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : spi_pkg                                              |
// | Description : Shared types and constants for the SPI master: FSM   |
// |               state type and encodings, byte width, default clock  |
// |               divider and the half-period counter width.           |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package spi_pkg;

   // Bits per SPI transfer.
   localparam int BYTE_W          = 8;

   // Default clk cycles per SCK half-period.
   localparam int CLK_DIV_DEFAULT = 4;

   // Width of the half-period and idle counters; fits any divider up to 255.
   localparam int CNT_W           = 8;

   // FSM state type with explicit, stable encodings.
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_SETUP   = 3'd1;
   localparam state_t ST_SHIFT   = 3'd2;
   localparam state_t ST_HOLD    = 3'd3;
   localparam state_t ST_RELEASE = 3'd4;

   // Where the FSM goes once a byte has fully shifted out.
   function automatic state_t after_byte(input logic last);
      return last ? ST_RELEASE : ST_HOLD;
   endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_clkgen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : spi_clkgen                                           |
// | Description : SCK half-period timer. A down-counter runs from      |
// |               CLK_DIV-1 to 0 and reloads; tick strobes on the      |
// |               terminal count. While hold is high the counter is    |
// |               parked at CLK_DIV-1 so a new phase starts full.      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module spi_clkgen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic hold,
   output logic tick
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] count;

   // Half-period down-counter: parked while held, reloads on terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (hold) begin
         count <= RELOAD;
      end else if (count == '0) begin
         count <= RELOAD;
      end else begin
         count <= count - 1'b1;
      end
   end

   // The tick is suppressed while held so a parked counter never fires.
   assign tick = !hold && (count == '0);

endmodule : spi_clkgen
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : spi_master                                           |
// | Description : Single-byte SPI mode-0 master with chip-select       |
// |               chaining. Bytes are requested with a valid/ready     |
// |               handshake; tx_last decides whether SSEL is released  |
// |               after the byte or held low for a following byte.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BYTE_W-1:0] tx_data,
   input  logic              tx_last,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              SCK,
   output logic              MOSI,
   input  logic              MISO,
   output logic              SSEL
);

   // Last idle-counter value before tx_ready may rise.
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [2:0]       LAST_FALL = 3'(BYTE_W - 1);

   state_t            state;
   logic              tick;
   logic              hold;
   logic              accept;
   logic              rise_evt;
   logic              fall_evt;
   logic              last_fall;
   logic              last_byte;
   logic [2:0]        fall_cnt;
   logic [BYTE_W-2:0] tx_sh;
   logic [BYTE_W-1:0] rx_sh;
   logic [CNT_W-1:0]  idle_cnt;

   // The half-period timer only runs while a byte is being framed or shifted.
   assign hold = (state == ST_IDLE) || (state == ST_HOLD);

   spi_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk   (clk),
      .rst_n (rst_n),
      .hold  (hold),
      .tick  (tick)
   );

   // tx_ready is only ever high in IDLE or HOLD, so this is the full accept test.
   assign accept    = tx_valid && tx_ready;

   // The SETUP terminal count is the first SCK rise; later ones alternate in SHIFT.
   assign rise_evt  = tick && ((state == ST_SETUP) || ((state == ST_SHIFT) && !SCK));
   assign fall_evt  = tick && (state == ST_SHIFT) && SCK;
   assign last_fall = fall_evt && (fall_cnt == LAST_FALL);

   // Control FSM: state sequencing, chip select, handshake and IDLE guard time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         SSEL      <= 1'b1;
         tx_ready  <= 1'b0;
         idle_cnt  <= '0;
         last_byte <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state     <= ST_SETUP;
                  SSEL      <= 1'b0;
                  tx_ready  <= 1'b0;
                  last_byte <= tx_last;
               end else if (!tx_ready) begin
                  // Guarantee SSEL stays high for a full half-period.
                  if (idle_cnt == IDLE_LAST) begin
                     tx_ready <= 1'b1;
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               // Chained byte: SSEL is never touched on this path.
               if (accept) begin
                  state     <= ST_SETUP;
                  tx_ready  <= 1'b0;
                  last_byte <= tx_last;
               end
            end
            ST_SETUP: begin
               if (tick) begin
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (last_fall) begin
                  state    <= after_byte(last_byte);
                  tx_ready <= !last_byte;
               end
            end
            ST_RELEASE: begin
               if (tick) begin
                  state    <= ST_IDLE;
                  SSEL     <= 1'b1;
                  idle_cnt <= '0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               SSEL     <= 1'b1;
               tx_ready <= 1'b0;
               idle_cnt <= '0;
            end
         endcase
      end
   end

   // SCK generator: mode 0, idles low, toggles only on timer events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         SCK <= 1'b0;
      end else if (rise_evt) begin
         SCK <= 1'b1;
      end else if (fall_evt) begin
         SCK <= 1'b0;
      end
   end

   // Transmit path: MSB presented on accept, next bit on falls 1..7, else held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         MOSI  <= 1'b0;
         tx_sh <= '0;
      end else if (accept) begin
         MOSI  <= tx_data[BYTE_W-1];
         tx_sh <= tx_data[BYTE_W-2:0];
      end else if (fall_evt && !last_fall) begin
         MOSI  <= tx_sh[BYTE_W-2];
         tx_sh <= {tx_sh[BYTE_W-3:0], 1'b0};
      end
   end

   // Receive path: sample MISO on each rise, publish the byte on the 8th fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sh    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         fall_cnt <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (accept) begin
            fall_cnt <= '0;
         end
         if (rise_evt) begin
            rx_sh <= {rx_sh[BYTE_W-2:0], MISO};
         end
         if (fall_evt) begin
            fall_cnt <= fall_cnt + 3'd1;
            if (last_fall) begin
               rx_data  <= rx_sh;
               rx_valid <= 1'b1;
            end
         end
      end
   end

endmodule : spi_master
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_spi_master                                        |
// | Description : Directed self-checking bench for spi_master with a   |
// |               CLK_DIV=4 instance and a CLK_DIV=2 instance.         |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst_n;

   // CLK_DIV=4 instance
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       sck;
   logic       mosi;
   logic       miso;
   logic       ssel;
   logic       miso_loop;
   logic       miso_force;

   // CLK_DIV=2 instance
   logic [7:0] tx_data2;
   logic       tx_last2;
   logic       tx_valid2;
   logic       tx_ready2;
   logic [7:0] rx_data2;
   logic       rx_valid2;
   logic       sck2;
   logic       mosi2;
   logic       miso2;
   logic       ssel2;

   int vec_cnt = 0;
   int err_cnt = 0;

   assign miso  = miso_loop ? mosi : miso_force;
   assign miso2 = mosi2;

   always #5 clk = ~clk;

   spi_master #(.CLK_DIV(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_last(tx_last),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .SCK(sck), .MOSI(mosi), .MISO(miso), .SSEL(ssel)
   );

   spi_master #(.CLK_DIV(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_last(tx_last2),
      .tx_valid(tx_valid2), .tx_ready(tx_ready2), .rx_data(rx_data2),
      .rx_valid(rx_valid2), .SCK(sck2), .MOSI(mosi2), .MISO(miso2), .SSEL(ssel2)
   );

   // Bus monitor for the CLK_DIV=4 instance, sampled on the falling clk edge.
   int          cyc = 0;
   logic        prev_sck = 1'b0;
   logic        prev_ssel = 1'b1;
   logic        mon_clr = 1'b1;
   int          rise_cnt = 0, fall_cnt = 0, rx_cnt = 0;
   int          ssel_rises = 0, ssel_falls = 0;
   int          ssel_low_cyc = 0, first_rise_cyc = 0, fall8_cyc = 0, ssel_high_cyc = 0;
   logic [15:0] mosi_cap = '0;
   logic        mosi_or = 1'b0;
   logic [7:0]  rx_last = '0;

   always @(negedge clk) begin
      cyc++;
      if (mon_clr) begin
         rise_cnt = 0; fall_cnt = 0; rx_cnt = 0;
         ssel_rises = 0; ssel_falls = 0;
         ssel_low_cyc = 0; first_rise_cyc = 0; fall8_cyc = 0; ssel_high_cyc = 0;
         mosi_cap = '0; mosi_or = 1'b0; rx_last = '0;
      end else begin
         if (sck && !prev_sck) begin
            rise_cnt++;
            if (rise_cnt == 1) first_rise_cyc = cyc;
            mosi_cap = {mosi_cap[14:0], mosi};
         end
         if (!sck && prev_sck) begin
            fall_cnt++;
            if (fall_cnt == 8) fall8_cyc = cyc;
         end
         if (!ssel && prev_ssel) begin ssel_falls++; ssel_low_cyc = cyc; end
         if (ssel && !prev_ssel) begin ssel_rises++; ssel_high_cyc = cyc; end
         if (rx_valid) begin rx_cnt++; rx_last = rx_data; end
         if (!ssel && mosi) mosi_or = 1'b1;
      end
      prev_sck  = sck;
      prev_ssel = ssel;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      int n = 0;
      @(negedge clk);
      while (!tx_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_val("tx_ready_wait", 32'(tx_ready), 32'd1);
      tx_data  = d;
      tx_last  = last;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!(ssel && tx_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_val("done_wait", 32'(ssel && tx_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nr, r1, r2, seen2;
      logic p2;
      logic [7:0] bits2, rxv2;

      rst_n = 1'b0;
      tx_data = '0;  tx_last = 1'b0;  tx_valid = 1'b0;
      tx_data2 = '0; tx_last2 = 1'b0; tx_valid2 = 1'b0;
      miso_loop = 1'b1; miso_force = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check_val("rst_sck",      32'(sck),      32'd0);
      check_val("rst_ssel",     32'(ssel),     32'd1);
      check_val("rst_mosi",     32'(mosi),     32'd0);
      check_val("rst_tx_ready", 32'(tx_ready), 32'd0);
      check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
      check_val("rst_rx_data",  32'(rx_data),  32'h00);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_ready_early", 32'(tx_ready), 32'd0);
      @(negedge clk);
      check_val("rst_ready_rise",  32'(tx_ready), 32'd1);

      // 0xA5 loopback, single byte
      clr_mon();
      send(8'hA5, 1'b1);
      wait_done();
      check_val("a5_mosi_bits",  32'(mosi_cap[7:0]), 32'hA5);
      check_val("a5_rx_data",    32'(rx_last),       32'hA5);
      check_val("a5_rx_port",    32'(rx_data),       32'hA5);
      check_val("a5_rx_pulses",  32'(rx_cnt),        32'd1);
      check_val("a5_sck_rises",  32'(rise_cnt),      32'd8);
      check_val("a5_setup_cyc",  32'(first_rise_cyc - ssel_low_cyc), 32'd4);
      check_val("a5_release_cyc",32'(ssel_high_cyc - fall8_cyc),     32'd4);

      // 0x3C then 0xC3 chained under one SSEL
      clr_mon();
      send(8'h3C, 1'b0);
      send(8'hC3, 1'b1);
      wait_done();
      check_val("b2b_ssel_falls", 32'(ssel_falls), 32'd1);
      check_val("b2b_ssel_rises", 32'(ssel_rises), 32'd1);
      check_val("b2b_rx_pulses",  32'(rx_cnt),     32'd2);
      check_val("b2b_sck_rises",  32'(rise_cnt),   32'd16);
      check_val("b2b_mosi_bits",  32'(mosi_cap),   32'h3CC3);
      check_val("b2b_rx_last",    32'(rx_last),    32'hC3);

      // MISO tied high, transmit zeros
      miso_loop = 1'b0; miso_force = 1'b1;
      clr_mon();
      send(8'h00, 1'b1);
      wait_done();
      check_val("ones_rx_data",   32'(rx_last), 32'hFF);
      check_val("ones_mosi_high", 32'(mosi_or), 32'd0);
      check_val("ones_rx_pulses", 32'(rx_cnt),  32'd1);
      miso_loop = 1'b1;

      // Request held during SHIFT must be ignored
      clr_mon();
      send(8'h5A, 1'b1);
      n = 0;
      while (rise_cnt < 1 && n < 100) begin @(negedge clk); n++; end
      check_val("ign_shift_start", 32'(rise_cnt >= 1), 32'd1);
      tx_data = 8'hFF; tx_valid = 1'b1;
      n = 0;
      while (rx_cnt < 1 && n < 200) begin @(negedge clk); n++; end
      tx_valid = 1'b0;
      check_val("ign_rx_seen", 32'(rx_cnt), 32'd1);
      wait_done();
      repeat (10) @(negedge clk);
      check_val("ign_sck_rises",  32'(rise_cnt),       32'd8);
      check_val("ign_mosi_bits",  32'(mosi_cap[7:0]),  32'h5A);
      check_val("ign_rx_data",    32'(rx_last),        32'h5A);
      check_val("ign_ssel_falls", 32'(ssel_falls),     32'd1);

      // Reset asserted after the 3rd SCK rise
      clr_mon();
      send(8'hA5, 1'b1);
      n = 0;
      while (rise_cnt < 3 && n < 200) begin @(negedge clk); n++; end
      check_val("mid_sck_high", 32'(sck), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_sck",     32'(sck),      32'd0);
      check_val("mid_rst_ssel",    32'(ssel),     32'd1);
      check_val("mid_rst_rx_data", 32'(rx_data),  32'h00);
      check_val("mid_rst_ready",   32'(tx_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_val("mid_ready_early", 32'(tx_ready), 32'd0);
      @(negedge clk);
      check_val("mid_ready_rise",  32'(tx_ready), 32'd1);
      repeat (20) @(negedge clk);
      check_val("mid_no_rx_valid", 32'(rx_cnt),   32'd0);

      // CLK_DIV=2 instance, 0x81
      n = 0;
      while (!tx_ready2 && n < 50) begin @(negedge clk); n++; end
      check_val("d2_tx_ready", 32'(tx_ready2), 32'd1);
      tx_data2 = 8'h81; tx_last2 = 1'b1; tx_valid2 = 1'b1;
      @(negedge clk);
      tx_valid2 = 1'b0;
      p2 = sck2; nr = 0; r1 = 0; r2 = 0; bits2 = '0;
      for (int i = 0; i < 200 && nr < 8; i++) begin
         @(negedge clk);
         if (sck2 && !p2) begin
            nr++;
            bits2 = {bits2[6:0], mosi2};
            if (nr == 1) r1 = i;
            if (nr == 2) r2 = i;
         end
         p2 = sck2;
      end
      check_val("d2_sck_rises",  32'(nr),      32'd8);
      check_val("d2_sck_period", 32'(r2 - r1), 32'd4);
      check_val("d2_mosi_bits",  32'(bits2),   32'h81);
      seen2 = 0; rxv2 = '0;
      for (int i = 0; i < 50 && seen2 == 0; i++) begin
         @(negedge clk);
         if (rx_valid2) begin seen2 = 1; rxv2 = rx_data2; end
      end
      check_val("d2_rx_valid", 32'(seen2), 32'd1);
      check_val("d2_rx_data",  32'(rxv2),  32'h81);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule : tb_spi_master
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCK half-period (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port tx_data, input, 8, the byte to transmit, MSB first.
REQ-005 The block SHALL have port tx_last, input, 1; when high, SSEL is released after this byte.
REQ-006 The block SHALL have port tx_valid, input, 1, the byte-request strobe.
REQ-007 The block SHALL have port tx_ready, output, 1; high when a request can be accepted.
REQ-008 The block SHALL have port rx_data, output, 8, the byte received on MISO.
REQ-009 The block SHALL have port rx_valid, output, 1; one-cycle pulse when rx_data is updated.
REQ-010 The block SHALL have ports SCK (output, 1), MOSI (output, 1), MISO (input, 1) and SSEL (output, 1, active low).

Function
REQ-011 The block SHALL implement SPI mode 0: SCK idles low, MISO sampled on SCK rise, MOSI changes on SCK fall.
REQ-012 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and RELEASE.
REQ-013 tx_ready SHALL be high only in IDLE and HOLD; a request is accepted on a cycle with tx_valid and tx_ready both high.
REQ-014 On acceptance, tx_data and tx_last SHALL be registered, the block SHALL enter SETUP, SSEL SHALL be low from the next cycle, and MOSI SHALL present bit 7.
REQ-015 SETUP SHALL last CLK_DIV cycles, then SHIFT begins with the first SCK rise.
REQ-016 In SHIFT, SCK SHALL toggle every CLK_DIV cycles, giving exactly 8 rises and 8 falls per byte.
REQ-017 At each SCK rise, MISO SHALL be shifted into the receive register LSB-first-in (MSB received first).
REQ-018 At SCK falls 1 to 7, MOSI SHALL advance to the next lower bit.
REQ-019 At the 8th SCK fall, rx_data SHALL be updated and rx_valid SHALL pulse for one cycle.
REQ-020 After the 8th fall, the FSM SHALL enter RELEASE if tx_last was 1, otherwise HOLD.
REQ-021 In HOLD, SSEL SHALL stay low and SCK low; an accepted request SHALL go straight to SETUP without SSEL deassertion.
REQ-022 RELEASE SHALL keep SSEL low for CLK_DIV cycles, then drive SSEL high and enter IDLE; IDLE SHALL last at least CLK_DIV cycles before tx_ready rises.
REQ-023 tx_valid SHALL be ignored while tx_ready is low; no request is queued.
REQ-024 MOSI SHALL hold its last value while SSEL is high.
REQ-025 The half-period counter SHALL count from CLK_DIV-1 down to 0, reload on the terminal count, and be held at CLK_DIV-1 in IDLE and HOLD.

Reset
REQ-026 Asserting rst_n low SHALL immediately force: state IDLE, SCK 0, SSEL 1, MOSI 0, tx_ready 0, rx_valid 0, rx_data 0x00, counters 0.
REQ-027 After rst_n deasserts, tx_ready SHALL rise after CLK_DIV cycles.
REQ-028 Reset asserted mid-byte SHALL abort the transfer without an rx_valid pulse.

Structure
REQ-029 Shared package spi_pkg SHALL hold the state enum type, the byte width constant (8) and the CLK_DIV default.
REQ-030 Sub-module spi_clkgen SHALL provide the half-period tick (counter plus terminal-count strobe); the FSM and shift registers SHALL stay in spi_master.

Verification (CLK_DIV=4 unless stated)
REQ-031 Scenario: send 0xA5 with tx_last=1 and MISO looped to MOSI -> MOSI bits 1,0,1,0,0,1,0,1; rx_data=0xA5; one rx_valid pulse; SSEL low-to-first-SCK-rise = 4 cycles; SSEL high 4 cycles after the 8th fall.
REQ-032 Scenario: send 0x3C (tx_last=0) then 0xC3 (tx_last=1) back-to-back -> SSEL low continuously; two rx_valid pulses; 16 SCK rises.
REQ-033 Scenario: MISO tied 1, send 0x00 -> rx_data=0xFF, MOSI constant 0.
REQ-034 Scenario: rst_n pulsed low after the 3rd SCK rise -> SCK=0 and SSEL=1 in the same cycle; no rx_valid; tx_ready high 4 cycles after release.
REQ-035 Scenario: tx_valid held high throughout SHIFT with data 0xFF -> ignored; only the original byte is sent.
REQ-036 Scenario: CLK_DIV=2, send 0x81 -> SCK period 4 cycles; MOSI pattern 1,0,0,0,0,0,0,1.
